alu_exc_handler: RTL and testbench

ALU_EXC_HANDLER -- requirements
Module: alu_exc_handler

---
 rtl/alu_exc_handler_pkg.sv | 32 +++
 rtl/alu_exc_prio_enc.sv | 17 +
 rtl/alu_exc_handler.sv | 110 +++++++++++
 tb/tb_alu_exc_handler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_exc_handler_pkg.sv
// rtl/alu_exc_handler_pkg.sv - shared FSM state, cause codes and ALU_status bit indices
package alu_exc_handler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } exc_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_OVF      = 2'd1,
    CAUSE_INV_ADDR = 2'd2,
    CAUSE_DIV0     = 2'd3
  } exc_cause_t;

  localparam int STAT_ZERO     = 7;
  localparam int STAT_OVF      = 6;
  localparam int STAT_CARRY    = 5;
  localparam int STAT_NEG      = 4;
  localparam int STAT_INV_ADDR = 3;
  localparam int STAT_DIV0     = 2;

  // Bits [1:0] of ALU_status are reserved and never stored.
  localparam logic [7:0] STATUS_KEEP = 8'hFC;

  // Mask bit positions within exc_mask and the masked-hit vector.
  localparam int MSK_OVF      = 0;
  localparam int MSK_INV_ADDR = 1;
  localparam int MSK_DIV0     = 2;

endpackage

// File: rtl/alu_exc_prio_enc.sv
// rtl/alu_exc_prio_enc.sv - priority encoder from masked exception hits to a cause code
module alu_exc_prio_enc
  import alu_exc_handler_pkg::*;
(
  input  logic [2:0] hits,
  output logic [1:0] cause
);

  // Invalid address outranks divide by zero, which outranks overflow.
  always_comb begin
    cause = CAUSE_NONE;
    if (hits[MSK_INV_ADDR])      cause = CAUSE_INV_ADDR;
    else if (hits[MSK_DIV0])     cause = CAUSE_DIV0;
    else if (hits[MSK_OVF])      cause = CAUSE_OVF;
  end

endmodule

// File: rtl/alu_exc_handler.sv
// rtl/alu_exc_handler.sv - ALU exception capture, request/ack handshake and status tracking
module alu_exc_handler
  import alu_exc_handler_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ALU_valid,
  input  logic [7:0]       ALU_status,
  input  logic [31:0]      ALU_result,
  input  logic [31:0]      PC_in,
  input  logic [2:0]       exc_mask,
  input  logic             exc_ack,
  input  logic             clear_sticky,
  output logic [7:0]       status_reg,
  output logic [7:0]       sticky_flags,
  output logic             exc_req,
  output logic [1:0]       exc_cause,
  output logic [31:0]      EPC,
  output logic [31:0]      bad_result,
  output logic [CNT_W-1:0] exc_count,
  output logic             exc_lost,
  output logic             exc_timeout,
  output logic             stall
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  exc_state_t       state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [2:0]       hits;
  logic [1:0]       new_cause;
  logic             exc_any;
  logic             timeout_hit;
  logic [7:0]       valid_flags;

  assign hits[MSK_OVF]      = ALU_valid & ALU_status[STAT_OVF]      & exc_mask[MSK_OVF];
  assign hits[MSK_INV_ADDR] = ALU_valid & ALU_status[STAT_INV_ADDR] & exc_mask[MSK_INV_ADDR];
  assign hits[MSK_DIV0]     = ALU_valid & ALU_status[STAT_DIV0]     & exc_mask[MSK_DIV0];
  assign exc_any            = |hits;
  assign valid_flags        = ALU_valid ? (ALU_status & STATUS_KEEP) : 8'h00;
  assign timeout_hit        = (state == ST_REQ) && !exc_ack && (tmo_cnt == TMO_LAST);

  alu_exc_prio_enc u_prio_enc (
    .hits  (hits),
    .cause (new_cause)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      status_reg   <= '0;
      sticky_flags <= '0;
      exc_req      <= 1'b0;
      exc_cause    <= CAUSE_NONE;
      EPC          <= '0;
      bad_result   <= '0;
      exc_count    <= '0;
      exc_lost     <= 1'b0;
      exc_timeout  <= 1'b0;
      stall        <= 1'b0;
    end else begin
      if (ALU_valid) status_reg <= valid_flags;
      // A flag arriving together with clear_sticky survives the clear.
      sticky_flags <= (clear_sticky ? 8'h00 : sticky_flags) | valid_flags;
      exc_lost     <= (clear_sticky ? 1'b0 : exc_lost) | (exc_any && (state != ST_IDLE));
      exc_timeout  <= (clear_sticky ? 1'b0 : exc_timeout) | timeout_hit;

      case (state)
        ST_IDLE: begin
          if (exc_any) begin
            state      <= ST_REQ;
            exc_req    <= 1'b1;
            stall      <= 1'b1;
            EPC        <= PC_in;
            bad_result <= ALU_result;
            exc_cause  <= new_cause;
            tmo_cnt    <= '0;
            if (exc_count != {CNT_W{1'b1}}) exc_count <= exc_count + 1'b1;
          end
        end
        ST_REQ: begin
          if (exc_ack) begin
            state   <= ST_DRAIN;
            exc_req <= 1'b0;
          end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          state     <= ST_IDLE;
          stall     <= 1'b0;
          exc_cause <= CAUSE_NONE;
        end
        default: begin
          state     <= ST_IDLE;
          exc_req   <= 1'b0;
          stall     <= 1'b0;
          exc_cause <= CAUSE_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exc_handler.sv
// tb/tb_alu_exc_handler.sv - directed self-checking bench for alu_exc_handler
module tb_alu_exc_handler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ALU_valid;
  logic [7:0]  ALU_status;
  logic [31:0] ALU_result;
  logic [31:0] PC_in;
  logic [2:0]  exc_mask;
  logic        exc_ack;
  logic        clear_sticky;

  logic [7:0]  status_reg, sticky_flags;
  logic        exc_req, exc_lost, exc_timeout, stall;
  logic [1:0]  exc_cause;
  logic [31:0] EPC, bad_result;
  logic [7:0]  exc_count;

  logic [7:0]  s_status_reg, s_sticky_flags;
  logic        s_exc_req, s_exc_lost, s_exc_timeout, s_stall;
  logic [1:0]  s_exc_cause;
  logic [31:0] s_EPC, s_bad_result;
  logic [1:0]  s_exc_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exc_handler dut (
    .clk(clk), .rst(rst), .ALU_valid(ALU_valid), .ALU_status(ALU_status),
    .ALU_result(ALU_result), .PC_in(PC_in), .exc_mask(exc_mask), .exc_ack(exc_ack),
    .clear_sticky(clear_sticky), .status_reg(status_reg), .sticky_flags(sticky_flags),
    .exc_req(exc_req), .exc_cause(exc_cause), .EPC(EPC), .bad_result(bad_result),
    .exc_count(exc_count), .exc_lost(exc_lost), .exc_timeout(exc_timeout), .stall(stall)
  );

  alu_exc_handler #(.CNT_W(2), .ACK_TIMEOUT(16)) dut_sat (
    .clk(clk), .rst(rst), .ALU_valid(ALU_valid), .ALU_status(ALU_status),
    .ALU_result(ALU_result), .PC_in(PC_in), .exc_mask(exc_mask), .exc_ack(exc_ack),
    .clear_sticky(clear_sticky), .status_reg(s_status_reg), .sticky_flags(s_sticky_flags),
    .exc_req(s_exc_req), .exc_cause(s_exc_cause), .EPC(s_EPC), .bad_result(s_bad_result),
    .exc_count(s_exc_count), .exc_lost(s_exc_lost), .exc_timeout(s_exc_timeout), .stall(s_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic retire(input logic [7:0] st, input logic [2:0] msk,
                        input logic [31:0] pc, input logic [31:0] res);
    ALU_valid  = 1'b1;
    ALU_status = st;
    exc_mask   = msk;
    PC_in      = pc;
    ALU_result = res;
    step();
    ALU_valid  = 1'b0;
  endtask

  task automatic ack_and_drain();
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; ALU_valid = 1'b0; ALU_status = 8'h00; ALU_result = 32'h0;
    PC_in = 32'h0; exc_mask = 3'b000; exc_ack = 1'b0; clear_sticky = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_exc_req", {31'b0, exc_req}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_count", {24'b0, exc_count}, 32'd0);
    check("rst_epc", EPC, 32'h0);
    check("rst_cause", {30'b0, exc_cause}, 32'd0);
    check("rst_sticky", {24'b0, sticky_flags}, 32'd0);

    // Overflow enabled: request one cycle later with captured context.
    retire(8'h40, 3'b001, 32'h100, 32'hDEAD0001);
    check("ovf_exc_req", {31'b0, exc_req}, 32'd1);
    check("ovf_stall", {31'b0, stall}, 32'd1);
    check("ovf_cause", {30'b0, exc_cause}, 32'd1);
    check("ovf_epc", EPC, 32'h100);
    check("ovf_bad_result", bad_result, 32'hDEAD0001);
    check("ovf_count", {24'b0, exc_count}, 32'd1);
    check("ovf_status_reg", {24'b0, status_reg}, 32'h40);

    // Second overflow while pending is lost; context is kept.
    retire(8'h40, 3'b001, 32'h200, 32'h0BAD0002);
    check("lost_flag", {31'b0, exc_lost}, 32'd1);
    check("lost_epc", EPC, 32'h100);
    check("lost_count", {24'b0, exc_count}, 32'd1);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    check("drain_exc_req", {31'b0, exc_req}, 32'd0);
    check("drain_stall", {31'b0, stall}, 32'd1);
    step();
    check("idle_stall", {31'b0, stall}, 32'd0);
    check("idle_cause", {30'b0, exc_cause}, 32'd0);

    // Ack outside REQ is ignored.
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    check("stray_ack_req", {31'b0, exc_req}, 32'd0);
    check("stray_ack_stall", {31'b0, stall}, 32'd0);

    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    check("clr_lost", {31'b0, exc_lost}, 32'd0);
    check("clr_sticky", {24'b0, sticky_flags}, 32'd0);

    // Reserved bits dropped; disabled cause does not trigger.
    retire(8'h03, 3'b111, 32'h280, 32'h1);
    check("resv_status_reg", {24'b0, status_reg}, 32'h00);
    check("resv_no_req", {31'b0, exc_req}, 32'd0);
    retire(8'h40, 3'b110, 32'h290, 32'h2);
    check("masked_no_req", {31'b0, exc_req}, 32'd0);

    // Priority: invalid address over div0 over overflow.
    retire(8'h4C, 3'b111, 32'h300, 32'h3);
    check("prio_all_cause", {30'b0, exc_cause}, 32'd2);
    check("prio_all_count", {24'b0, exc_count}, 32'd2);
    check("prio_sticky", {24'b0, sticky_flags}, 32'h4C);
    ack_and_drain();
    retire(8'h4C, 3'b101, 32'h400, 32'h4);
    check("prio_101_cause", {30'b0, exc_cause}, 32'd3);
    check("prio_101_epc", EPC, 32'h400);
    ack_and_drain();

    // Fourth accepted exception: saturates the 2-bit counter; then let it time out.
    retire(8'h04, 3'b100, 32'h500, 32'h5);
    check("cnt_main", {24'b0, exc_count}, 32'd4);
    check("cnt_sat", {30'b0, s_exc_count}, 32'd3);
    check("to_cause_div0", {30'b0, exc_cause}, 32'd3);
    step(14);
    check("to_early", {31'b0, exc_timeout}, 32'd0);
    step(2);
    check("to_flag", {31'b0, exc_timeout}, 32'd1);
    check("to_exc_req", {31'b0, exc_req}, 32'd1);

    // Clear with a coincident new flag: timeout clears, new flag survives.
    clear_sticky = 1'b1;
    ALU_valid = 1'b1; ALU_status = 8'h10; exc_mask = 3'b111;
    step();
    clear_sticky = 1'b0; ALU_valid = 1'b0;
    check("clr_timeout", {31'b0, exc_timeout}, 32'd0);
    check("clr_new_flag", {24'b0, sticky_flags}, 32'h10);
    check("clr_still_req", {31'b0, exc_req}, 32'd1);

    // Reset while pending drops the exception.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rreq_exc_req", {31'b0, exc_req}, 32'd0);
    check("rreq_stall", {31'b0, stall}, 32'd0);
    check("rreq_epc", EPC, 32'h0);
    check("rreq_count", {24'b0, exc_count}, 32'd0);
    check("rreq_bad_result", bad_result, 32'h0);
    step();
    check("rreq_no_ack_needed", {31'b0, exc_req}, 32'd0);
    retire(8'h40, 3'b001, 32'h600, 32'h6);
    check("post_rst_req", {31'b0, exc_req}, 32'd1);
    check("post_rst_count", {24'b0, exc_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
